sdmod_tx: RTL

Digital sigma-delta modulator transmitter: converts 16-bit signed samples into a 1-bit sigma-delta stream on DSDOUT with an optional companion SDCLK. The stream is electrically and temporally compatible with the channel input-control modes, so it can drive the filter channels as a loopback/self-test source or as a bitstream DAC output. The block sits beside the channels and is fed by the register interface.

---
 rtl/sdmod_tx_if.sv | 31 +++
 rtl/sdmod_tx.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/sdmod_tx_if.sv
// -----------------------------------------------------------------------------
// sdmod_tx_if
//   Sample handshake between the register interface (master) and the
//   sigma-delta transmitter (slave).
//
//   data_in          master -> slave  16-bit signed sample
//   data_wr_signal   master -> slave  one-cycle pulse, load data_in as pending
//   data_req_signal  slave -> master  one-cycle pulse, pending sample consumed
//   underrun_signal  slave -> master  one-cycle pulse, sample boundary found
//                                     no pending sample
// -----------------------------------------------------------------------------
interface sdmod_tx_if;
   logic [15:0] data_in;
   logic        data_wr_signal;
   logic        data_req_signal;
   logic        underrun_signal;

   modport master (
      output data_in,
      output data_wr_signal,
      input  data_req_signal,
      input  underrun_signal
   );

   modport slave (
      input  data_in,
      input  data_wr_signal,
      output data_req_signal,
      output underrun_signal
   );
endinterface

// File: rtl/sdmod_tx.sv
// -----------------------------------------------------------------------------
// sdmod_tx
//   Digital sigma-delta modulator transmitter. Turns 16-bit signed samples into
//   a 1-bit stream on DSDOUT, with an optional bit clock on SDCLK, in a form
//   the filter channels accept directly (loopback / self-test / bitstream DAC).
//
//   SYSCLK      system clock
//   SYSRSTn     asynchronous active-low reset
//   en_reg      transmitter enable
//   mod_reg     0 clk+data (data moves on SDCLK fall), 1 clk+data (data moves
//               on SDCLK rise), 2 Manchester, 3 NRZ data only
//   div_reg     bit period T = 2*(div_reg+1) SYSCLK cycles
//   osr_reg     bits per sample = osr_reg+1
//   order_reg   0 first-order loop, 1 second-order loop
//   smp         sample handshake (data_in / data_wr_signal in,
//               data_req_signal / underrun_signal out)
//   DSDOUT      modulated stream
//   SDCLK       bit clock, 0 in modes 2/3
//   busy        registered enable
// -----------------------------------------------------------------------------
module sdmod_tx (
   input  logic       SYSCLK,
   input  logic       SYSRSTn,
   input  logic       en_reg,
   input  logic [1:0] mod_reg,
   input  logic [3:0] div_reg,
   input  logic [7:0] osr_reg,
   input  logic       order_reg,
   sdmod_tx_if.slave  smp,
   output logic       DSDOUT,
   output logic       SDCLK,
   output logic       busy
);

   localparam logic signed [21:0] SAT_P = 22'sd524287;
   localparam logic signed [21:0] SAT_N = -22'sd524287;
   localparam logic signed [21:0] FB_P  = 22'sd32768;
   localparam logic signed [21:0] FB_N  = -22'sd32768;

   // Timing state
   logic              busy_q;
   logic [3:0]        half_q;
   logic              phase_q;
   logic [7:0]        bcnt_q;
   logic [3:0]        div_q;
   logic [1:0]        mod_q;

   // Sample path
   logic [15:0]       pending_q;
   logic              pend_q;
   logic [15:0]       held_q;

   // Modulator
   logic signed [19:0] i1_q;
   logic signed [19:0] i2_q;
   logic               bit_q;

   // Registered outputs
   logic              dsd_q;
   logic              sck_q;
   logic              req_q;
   logic              und_q;

   // Next-state / combinational
   logic              run;
   logic              bnd;
   logic              sbnd;
   logic [3:0]        div_e;
   logic [1:0]        mod_e;
   logic [15:0]       held_d;
   logic signed [21:0] x_w;
   logic signed [21:0] f_w;
   logic signed [21:0] s1;
   logic signed [21:0] s2;
   logic signed [19:0] i1_d;
   logic signed [19:0] i2_d;
   logic              bit_d;
   logic              dsd_d;
   logic              sck_d;

   function automatic logic signed [19:0] sat20(input logic signed [21:0] v);
      if (v > SAT_P)
         return SAT_P[19:0];
      else if (v < SAT_N)
         return SAT_N[19:0];
      else
         return v[19:0];
   endfunction

   always_comb begin
      // busy_q is the registered enable; the first cycle it is high is the
      // first boundary, since all counters sit at 0 while idle.
      run   = busy_q & en_reg;
      bnd   = run && (half_q == 4'd0) && !phase_q;
      sbnd  = bnd && (bcnt_q == 8'd0);

      // Config is picked up at the boundary itself, so the period that starts
      // there already runs with the new values. osr/order are only ever
      // consulted on a boundary, so they need no holding register.
      div_e = bnd ? div_reg : div_q;
      mod_e = bnd ? mod_reg : mod_q;

      held_d = held_q;
      if (sbnd && pend_q)
         held_d = pending_q;

      // Feedback uses the bit that is currently on the line.
      x_w  = {{6{held_d[15]}}, held_d};
      f_w  = bit_q ? FB_P : FB_N;
      s1   = {{2{i1_q[19]}}, i1_q} + x_w - f_w;
      i1_d = sat20(s1);
      s2   = {{2{i2_q[19]}}, i2_q} + {{2{i1_d[19]}}, i1_d} - f_w;
      i2_d = order_reg ? sat20(s2) : i2_q;
      bit_d = bit_q;
      if (bnd)
         bit_d = order_reg ? ~i2_d[19] : ~i1_d[19];

      // Line encoding from the current phase and the bit valid after this
      // cycle; registering it gives the one-cycle lag after boundary/wrap.
      sck_d = 1'b0;
      dsd_d = bit_d;
      case (mod_e)
         2'd0:    sck_d = phase_q;
         2'd1:    sck_d = ~phase_q;
         2'd2:    dsd_d = phase_q ? bit_d : ~bit_d;
         default: ;
      endcase
   end

   always_ff @(posedge SYSCLK or negedge SYSRSTn) begin
      if (!SYSRSTn) begin
         busy_q    <= 1'b0;
         half_q    <= '0;
         phase_q   <= 1'b0;
         bcnt_q    <= '0;
         div_q     <= '0;
         mod_q     <= '0;
         pending_q <= '0;
         pend_q    <= 1'b0;
         held_q    <= '0;
         i1_q      <= '0;
         i2_q      <= '0;
         bit_q     <= 1'b0;
         dsd_q     <= 1'b0;
         sck_q     <= 1'b0;
         req_q     <= 1'b0;
         und_q     <= 1'b0;
      end else begin
         busy_q <= en_reg;

         // Pending register lives outside the enable so software can preload.
         // A write on a sample-boundary cycle wins over the consume, so it
         // survives to the next sample boundary.
         if (smp.data_wr_signal) begin
            pending_q <= smp.data_in;
            pend_q    <= 1'b1;
         end else if (sbnd) begin
            pend_q    <= 1'b0;
         end

         if (!run) begin
            half_q  <= '0;
            phase_q <= 1'b0;
            bcnt_q  <= '0;
            div_q   <= '0;
            mod_q   <= '0;
            held_q  <= '0;
            i1_q    <= '0;
            i2_q    <= '0;
            bit_q   <= 1'b0;
            dsd_q   <= 1'b0;
            sck_q   <= 1'b0;
            req_q   <= 1'b0;
            und_q   <= 1'b0;
         end else begin
            if (half_q == div_e) begin
               half_q  <= '0;
               phase_q <= ~phase_q;
            end else begin
               half_q  <= half_q + 4'd1;
            end

            if (bnd) begin
               div_q  <= div_reg;
               mod_q  <= mod_reg;
               bcnt_q <= (bcnt_q == osr_reg) ? 8'd0 : bcnt_q + 8'd1;
               held_q <= held_d;
               i1_q   <= i1_d;
               i2_q   <= i2_d;
               bit_q  <= bit_d;
            end

            dsd_q <= dsd_d;
            sck_q <= sck_d;
            req_q <= sbnd & pend_q;
            und_q <= sbnd & ~pend_q;
         end
      end
   end

   assign DSDOUT              = dsd_q;
   assign SDCLK               = sck_q;
   assign busy                = busy_q;
   assign smp.data_req_signal = req_q;
   assign smp.underrun_signal = und_q;

endmodule
